// File: rtl/aes_engine.sv
// Iterative AES-128/192/256 engine with encrypt/decrypt select.
// The key schedule is expanded once per key load, then blocks run at one round per clk.
module aes_engine #(
  parameter int K = 128,
  localparam int NK = K / 32,
  localparam int NR = NK + 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [K-1:0]   key,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           dir,
  input  logic [127:0]   block_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   block_out,
  output logic           key_loaded
);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_badKey
    $error("aes_engine: K must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {NOKEY, KEYEXP, READY, RUN, HOLD} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gInv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sboxDir(input logic [7:0] b, input logic inv);
    logic [7:0] x;
    x = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
    x = gInv(x);
    if (!inv)
      x = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    return x;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sboxDir(w[31:24], 1'b0), sboxDir(w[23:16], 1'b0),
            sboxDir(w[15:8], 1'b0), sboxDir(w[7:0], 1'b0)};
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sboxDir(s[127-8*n -: 8], inv);
    return o;
  endfunction

  function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  // Row 0 coefficients; each later row is the same set rotated right by one.
  function automatic logic [127:0] mixCols(input logic [127:0] s, input logic inv);
    logic [31:0]  cf;
    logic [7:0]   acc;
    logic [127:0] o;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    o  = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], cf[31-8*((j-r+4)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  state_t        r_state, w_nextState;
  logic [31:0]   r_w [0:4*NR+3];
  logic [5:0]    r_wIdx;
  logic [2:0]    r_kCnt;
  logic [7:0]    r_rcon;
  logic [3:0]    r_round;
  logic          r_dir;
  logic [127:0]  r_aesState;
  logic [127:0]  r_blockOut;

  logic          w_keyAccept, w_blkAccept, w_lastWord, w_lastRound;
  logic [31:0]   w_prev, w_back, w_temp, w_newWord;
  logic [3:0]    w_rkIdx;
  logic [5:0]    w_rkBase;
  logic [127:0]  w_rk, w_subbed, w_mixIn, w_mixOut, w_pre, w_roundOut;

  always_comb begin
    w_nextState = r_state;
    key_ready   = 1'b0;
    in_ready    = 1'b0;
    unique case (r_state)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) w_nextState = KEYEXP;
      end
      KEYEXP: if (w_lastWord) w_nextState = READY;
      READY: begin
        key_ready = 1'b1;
        in_ready  = !key_valid;
        if (key_valid)     w_nextState = KEYEXP;
        else if (in_valid) w_nextState = RUN;
      end
      RUN:  if (w_lastRound) w_nextState = HOLD;
      HOLD: if (out_ready) w_nextState = READY;
      default: w_nextState = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= NOKEY;
    else        r_state <= w_nextState;
  end

  assign w_keyAccept = key_valid && key_ready;
  assign w_blkAccept = in_valid && in_ready;
  assign w_lastWord  = (r_wIdx == 6'(4*NR+3));
  assign w_lastRound = (r_round == 4'(NR));

  // Schedule word i: w[i-NK] ^ temp, with r_kCnt tracking i mod NK.
  assign w_prev = r_w[r_wIdx - 6'd1];
  assign w_back = r_w[r_wIdx - 6'(NK)];
  always_comb begin
    w_temp = w_prev;
    if (r_kCnt == 3'd0)
      w_temp = subWord({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_kCnt == 3'd4)
      w_temp = subWord(w_prev);
  end
  assign w_newWord = w_back ^ w_temp;

  always_comb begin
    w_rkIdx = dir ? 4'(NR) : 4'd0;
    if (r_state == RUN) w_rkIdx = r_dir ? (4'(NR) - r_round) : r_round;
  end
  assign w_rkBase = {w_rkIdx, 2'b00};
  assign w_rk = {r_w[w_rkBase], r_w[w_rkBase + 6'd1], r_w[w_rkBase + 6'd2], r_w[w_rkBase + 6'd3]};

  // Byte substitution commutes with row shifting, so both directions share one path.
  assign w_subbed   = subBytes(shiftRows(r_aesState, r_dir), r_dir);
  assign w_mixIn    = r_dir ? (w_subbed ^ w_rk) : w_subbed;
  assign w_mixOut   = mixCols(w_mixIn, r_dir);
  assign w_pre      = w_lastRound ? w_mixIn : w_mixOut;
  assign w_roundOut = r_dir ? w_pre : (w_pre ^ w_rk);

  always_ff @(posedge clk) begin
    if (w_keyAccept) begin
      for (int j = 0; j < NK; j++) r_w[j] <= key[K-1-32*j -: 32];
    end else if (r_state == KEYEXP) begin
      r_w[r_wIdx] <= w_newWord;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wIdx     <= '0;
      r_kCnt     <= '0;
      r_rcon     <= 8'h01;
      r_round    <= '0;
      r_dir      <= 1'b0;
      r_aesState <= '0;
      r_blockOut <= '0;
    end else begin
      if (w_keyAccept) begin
        r_wIdx <= 6'(NK);
        r_kCnt <= '0;
        r_rcon <= 8'h01;
      end else if (r_state == KEYEXP) begin
        r_wIdx <= r_wIdx + 6'd1;
        r_kCnt <= (r_kCnt == 3'(NK-1)) ? 3'd0 : r_kCnt + 3'd1;
        if (r_kCnt == 3'd0) r_rcon <= xtime(r_rcon);
      end
      if (w_blkAccept) begin
        r_dir      <= dir;
        r_aesState <= block_in ^ w_rk;
        r_round    <= 4'd1;
      end else if (r_state == RUN) begin
        r_aesState <= w_roundOut;
        if (w_lastRound) begin
          r_blockOut <= w_roundOut;
          r_round    <= '0;
        end else begin
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign block_out  = r_blockOut;
  assign key_loaded = (r_state == READY) || (r_state == RUN) || (r_state == HOLD);

endmodule

// File: tb/tb_aes_engine.sv
// Directed-vector bench for aes_engine: one instance per key size sharing clock, reset and data inputs.
module tb_aes_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   kv, iv, kr, ir, ov, kl;
  logic         dir, outReady;
  logic [255:0] keyBus;
  logic [127:0] blockIn;
  logic [127:0] bo [3];
  int           testsRun = 0;
  int           failCount = 0;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_engine #(.K(128)) u_dut128 (
    .clk(clk), .reset(reset), .key_valid(kv[0]), .key_ready(kr[0]), .key(keyBus[255:128]),
    .in_valid(iv[0]), .in_ready(ir[0]), .dir(dir), .block_in(blockIn), .out_valid(ov[0]),
    .out_ready(outReady), .block_out(bo[0]), .key_loaded(kl[0]));

  aes_engine #(.K(192)) u_dut192 (
    .clk(clk), .reset(reset), .key_valid(kv[1]), .key_ready(kr[1]), .key(keyBus[255:64]),
    .in_valid(iv[1]), .in_ready(ir[1]), .dir(dir), .block_in(blockIn), .out_valid(ov[1]),
    .out_ready(outReady), .block_out(bo[1]), .key_loaded(kl[1]));

  aes_engine #(.K(256)) u_dut256 (
    .clk(clk), .reset(reset), .key_valid(kv[2]), .key_ready(kr[2]), .key(keyBus),
    .in_valid(iv[2]), .in_ready(ir[2]), .dir(dir), .block_in(blockIn), .out_valid(ov[2]),
    .out_ready(outReady), .block_out(bo[2]), .key_loaded(kl[2]));

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadKey(input int sel, input logic [255:0] k, input int expClks, input string tag);
    int n;
    n = 0;
    while (!kr[sel] && n < 200) begin tick(); n++; end
    checkOutput({tag, " key_ready"}, 128'(kr[sel]), 128'd1);
    keyBus  = k;
    kv[sel] = 1'b1;
    tick();
    kv[sel] = 1'b0;
    checkOutput({tag, " key_loaded low"}, 128'(kl[sel]), 128'd0);
    n = 0;
    while (!kl[sel] && n < 200) begin tick(); n++; end
    checkOutput({tag, " expansion clks"}, 128'(n), 128'(expClks));
  endtask

  task automatic applyStimulus(input int sel, input logic d, input logic [127:0] blk,
                               input logic [127:0] exp, input int expLat, input string tag);
    int n;
    n = 0;
    while (!ir[sel] && n < 200) begin tick(); n++; end
    checkOutput({tag, " in_ready"}, 128'(ir[sel]), 128'd1);
    dir     = d;
    blockIn = blk;
    iv[sel] = 1'b1;
    tick();
    iv[sel] = 1'b0;
    dir     = ~d;
    blockIn = ~blk;
    n = 0;
    while (!ov[sel] && n < 100) begin tick(); n++; end
    checkOutput({tag, " latency"}, 128'(n), 128'(expLat));
    checkOutput({tag, " block_out"}, bo[sel], exp);
    if (outReady) begin
      tick();
      checkOutput({tag, " out_valid drop"}, 128'(ov[sel]), 128'd0);
    end
  endtask

  initial begin
    int errs;
    int n;
    reset    = 1'b0;
    kv       = '0;
    iv       = '0;
    dir      = 1'b0;
    outReady = 1'b1;
    keyBus   = '0;
    blockIn  = '0;
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("reset%0d out_valid", s), 128'(ov[s]), 128'd0);
      checkOutput($sformatf("reset%0d key_loaded", s), 128'(kl[s]), 128'd0);
      checkOutput($sformatf("reset%0d block_out", s), bo[s], 128'd0);
      checkOutput($sformatf("reset%0d key_ready", s), 128'(kr[s]), 128'd1);
      checkOutput($sformatf("reset%0d in_ready", s), 128'(ir[s]), 128'd0);
    end
    reset = 1'b1;
    tick();

    // A block offered with no key is never taken.
    blockIn = PT;
    iv[0]   = 1'b1;
    repeat (4) tick();
    checkOutput("nokey in_ready", 128'(ir[0]), 128'd0);
    iv[0] = 1'b0;
    tick();
    checkOutput("nokey out_valid", 128'(ov[0]), 128'd0);

    loadKey(0, KEY128, 40, "k128");
    applyStimulus(0, 1'b0, PT, CT128, 10, "enc128");
    applyStimulus(0, 1'b1, CT128, PT, 10, "dec128");

    outReady = 1'b0;
    applyStimulus(0, 1'b0, PT, CT128, 10, "bp128");
    errs = 0;
    repeat (20) begin
      tick();
      if (bo[0] !== CT128 || ov[0] !== 1'b1 || ir[0] !== 1'b0) errs++;
    end
    checkOutput("backpressure hold", 128'(errs), 128'd0);
    outReady = 1'b1;
    tick();
    checkOutput("bp release out_valid", 128'(ov[0]), 128'd0);
    checkOutput("bp release in_ready", 128'(ir[0]), 128'd1);

    // Key and block together: key wins, block is dropped.
    keyBus  = KEYB;
    blockIn = PT;
    dir     = 1'b0;
    kv[0]   = 1'b1;
    iv[0]   = 1'b1;
    tick();
    kv[0] = 1'b0;
    iv[0] = 1'b0;
    checkOutput("collide key_loaded", 128'(kl[0]), 128'd0);
    checkOutput("collide in_ready", 128'(ir[0]), 128'd0);
    n    = 0;
    errs = 0;
    while (!kl[0] && n < 200) begin
      tick();
      n++;
      if (ov[0] !== 1'b0) errs++;
    end
    checkOutput("collide expansion clks", 128'(n), 128'd40);
    checkOutput("collide no output", 128'(errs), 128'd0);

    applyStimulus(0, 1'b0, PTB, CTB, 10, "encB");
    applyStimulus(0, 1'b1, CTB, PTB, 10, "decB");
    applyStimulus(0, 1'b0, PTB, CTB, 10, "encB again");

    loadKey(1, KEY192, 46, "k192");
    applyStimulus(1, 1'b0, PT, CT192, 12, "enc192");
    applyStimulus(1, 1'b1, CT192, PT, 12, "dec192");

    loadKey(2, KEY256, 52, "k256");
    applyStimulus(2, 1'b0, PT, CT256, 14, "enc256");
    applyStimulus(2, 1'b1, CT256, PT, 14, "dec256");

    // Reset in the middle of a block aborts it.
    n = 0;
    while (!ir[0] && n < 200) begin tick(); n++; end
    dir     = 1'b0;
    blockIn = PT;
    iv[0]   = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("midrun reset out_valid", 128'(ov[0]), 128'd0);
    checkOutput("midrun reset key_loaded", 128'(kl[0]), 128'd0);
    checkOutput("midrun reset in_ready", 128'(ir[0]), 128'd0);
    checkOutput("midrun reset key_ready", 128'(kr[0]), 128'd1);
    checkOutput("midrun reset block_out", bo[0], 128'd0);
    reset = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
